// File: rtl/smart_cargo_top.sv
// Four-floor cargo lift controller: UART request receiver, request FIFO,
// floor tracking and the transport FSM with an ultrasonic-gated dwell.
module smart_cargo_top #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DWELL_CYCLES = 5000,
    parameter int TRIG_CYCLES  = 500,
    parameter int QDEPTH       = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       iniciar,
    input  logic [3:0] sensoresNeg,
    input  logic       emergencia,
    input  logic       RX,
    input  logic       echo,
    output logic       motorSubindoF,
    output logic       motorDescendoF,
    output logic       trigger_sensor_ultrasonico,
    output logic [1:0] saida_andar
);
    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int DW   = $clog2(DWELL_CYCLES);
    localparam int TW   = $clog2(TRIG_CYCLES + 1);
    localparam int PW   = $clog2(QDEPTH);
    localparam int NW   = $clog2(QDEPTH + 1);

    typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} uart_state_t;
    typedef enum logic [2:0] {IDLE, GO_ORIG, LOAD, GO_DEST, UNLOAD, EMERG} lift_state_t;

    logic [1:0] rx_sync, echo_sync, emerg_sync;
    logic [3:0] sens_meta, sens_s;
    logic       rx_d;
    logic       rx_s, echo_s, emerg_s;

    // NOTE: every clocked process uses non-blocking assignments so all flops
    // sample the values from before the edge, independent of process order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_sync    <= 2'b11;
            rx_d       <= 1'b1;
            echo_sync  <= 2'b00;
            emerg_sync <= 2'b00;
            sens_meta  <= 4'hF;
            sens_s     <= 4'hF;
        end else begin
            rx_sync    <= {rx_sync[0], RX};
            rx_d       <= rx_sync[1];
            echo_sync  <= {echo_sync[0], echo};
            emerg_sync <= {emerg_sync[0], emergencia};
            sens_meta  <= sensoresNeg;
            sens_s     <= sens_meta;
        end
    end

    assign rx_s    = rx_sync[1];
    assign echo_s  = echo_sync[1];
    assign emerg_s = emerg_sync[1];

    // UART receiver
    uart_state_t u_state, u_next;
    logic [CW-1:0] u_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          u_cnt_clr, u_sample, u_done, byte_valid;

    // NOTE: each output of a combinational block gets a default first so no
    // path through the case statement can leave it unassigned and infer a latch.
    always_comb begin
        u_next    = u_state;
        u_cnt_clr = 1'b0;
        u_sample  = 1'b0;
        u_done    = 1'b0;
        unique case (u_state)
            U_IDLE: if (rx_d && !rx_s) begin
                u_next    = U_START;
                u_cnt_clr = 1'b1;
            end
            U_START: if (u_cnt == CW'(HALF - 1)) begin
                u_cnt_clr = 1'b1;
                u_next    = rx_s ? U_IDLE : U_DATA;
            end
            U_DATA: if (u_cnt == CW'(CLKS_PER_BIT - 1)) begin
                u_cnt_clr = 1'b1;
                u_sample  = 1'b1;
                if (bit_idx == 3'd7) u_next = U_STOP;
            end
            U_STOP: if (u_cnt == CW'(CLKS_PER_BIT - 1)) begin
                u_cnt_clr = 1'b1;
                u_done    = rx_s;
                u_next    = U_IDLE;
            end
            default: u_next = U_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            u_state    <= U_IDLE;
            u_cnt      <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            byte_valid <= 1'b0;
        end else begin
            u_state    <= u_next;
            u_cnt      <= u_cnt_clr ? '0 : u_cnt + CW'(1);
            byte_valid <= u_done;
            if (u_state == U_IDLE) bit_idx <= '0;
            else if (u_sample)     bit_idx <= bit_idx + 3'd1;
            if (u_sample) shreg <= {rx_s, shreg[7:1]};
        end
    end

    // Request FIFO
    logic [5:0]    fifo_mem [QDEPTH];
    logic [5:0]    fifo_head;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [NW-1:0] fifo_count;
    logic          fifo_pop, fifo_push;

    assign fifo_push = byte_valid && (fifo_count != NW'(QDEPTH) || fifo_pop);
    assign fifo_head = fifo_mem[rd_ptr];

    // NOTE: the storage array carries no reset; emptiness is tracked by the
    // pointers and count alone, so stale entries are never observed.
    always_ff @(posedge clk) begin
        if (fifo_push) fifo_mem[wr_ptr] <= shreg[5:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (fifo_push) wr_ptr <= (wr_ptr == PW'(QDEPTH - 1)) ? '0 : wr_ptr + PW'(1);
            if (fifo_pop)  rd_ptr <= (rd_ptr == PW'(QDEPTH - 1)) ? '0 : rd_ptr + PW'(1);
            unique case ({fifo_push, fifo_pop})
                2'b10:   fifo_count <= fifo_count + NW'(1);
                2'b01:   fifo_count <= fifo_count - NW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Floor tracking: lowest active sensor wins; all-high holds the last floor.
    logic [1:0] floor_q, floor_c;

    always_comb begin
        floor_c = floor_q;
        for (int i = 3; i >= 0; i--) begin
            if (!sens_s[i]) floor_c = 2'(i);
        end
    end

    assign saida_andar = floor_q;

    // Transport FSM
    lift_state_t   state, next_state, saved_state;
    logic [1:0]    req_orig, req_dest, req_obj_unused, target;
    logic [DW-1:0] dwell_cnt;
    logic [TW-1:0] trig_cnt;
    logic          up_next, down_next, dwell_start, next_dwell;

    always_comb begin
        next_state  = state;
        fifo_pop    = 1'b0;
        up_next     = 1'b0;
        down_next   = 1'b0;
        dwell_start = 1'b0;
        target      = (state == GO_DEST) ? req_dest : req_orig;
        if (emerg_s) begin
            next_state = EMERG;
        end else begin
            unique case (state)
                IDLE: if (iniciar && fifo_count != '0) begin
                    next_state = GO_ORIG;
                    fifo_pop   = 1'b1;
                end
                GO_ORIG, GO_DEST: begin
                    if (floor_c == target) begin
                        next_state = (state == GO_ORIG) ? LOAD : UNLOAD;
                    end else begin
                        up_next   = target > floor_c;
                        down_next = target < floor_c;
                    end
                end
                LOAD, UNLOAD: if (dwell_cnt == DW'(DWELL_CYCLES - 1)) begin
                    // A high echo at expiry means the doorway is not confirmed clear.
                    if (echo_s) dwell_start = 1'b1;
                    else        next_state  = (state == LOAD) ? GO_DEST : IDLE;
                end
                EMERG:   next_state = saved_state;
                default: next_state = IDLE;
            endcase
        end
        next_dwell = (next_state == LOAD) || (next_state == UNLOAD);
        if (next_dwell && next_state != state) dwell_start = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state                      <= IDLE;
            saved_state                <= IDLE;
            floor_q                    <= 2'd0;
            req_orig                   <= 2'd0;
            req_dest                   <= 2'd0;
            req_obj_unused             <= 2'd0;
            dwell_cnt                  <= '0;
            trig_cnt                   <= '0;
            motorSubindoF              <= 1'b0;
            motorDescendoF             <= 1'b0;
            trigger_sensor_ultrasonico <= 1'b0;
        end else begin
            state          <= next_state;
            floor_q        <= floor_c;
            motorSubindoF  <= up_next;
            motorDescendoF <= down_next;
            if (next_state == EMERG && state != EMERG) saved_state <= state;
            if (fifo_pop) {req_obj_unused, req_dest, req_orig} <= fifo_head;

            if (dwell_start)
                dwell_cnt <= '0;
            else if (state == LOAD || state == UNLOAD)
                dwell_cnt <= dwell_cnt + DW'(1);

            if (dwell_start) begin
                trigger_sensor_ultrasonico <= 1'b1;
                trig_cnt                   <= TW'(TRIG_CYCLES - 1);
            end else if (!next_dwell || trig_cnt == '0) begin
                trigger_sensor_ultrasonico <= 1'b0;
                trig_cnt                   <= '0;
            end else begin
                trig_cnt <= trig_cnt - TW'(1);
            end
        end
    end

endmodule

// File: tb/tb_smart_cargo_top.sv
// Directed bench for smart_cargo_top with shortened UART/dwell/trigger
// timing; expected values are hand-derived from the cycle-level behaviour.
module tb_smart_cargo_top;
    localparam int CPB   = 16;
    localparam int DWELL = 200;
    localparam int TRIG  = 20;

    localparam int SIG_UP   = 0;
    localparam int SIG_DOWN = 1;
    localparam int SIG_TRIG = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       iniciar;
    logic [3:0] sensoresNeg;
    logic       emergencia;
    logic       RX;
    logic       echo;
    logic       motorSubindoF;
    logic       motorDescendoF;
    logic       trigger;
    logic [1:0] saida_andar;

    int n_checks = 0;
    int n_pass   = 0;

    smart_cargo_top #(
        .CLKS_PER_BIT(CPB),
        .DWELL_CYCLES(DWELL),
        .TRIG_CYCLES (TRIG),
        .QDEPTH      (4)
    ) dut (
        .clk                       (clk),
        .reset                     (reset),
        .iniciar                   (iniciar),
        .sensoresNeg               (sensoresNeg),
        .emergencia                (emergencia),
        .RX                        (RX),
        .echo                      (echo),
        .motorSubindoF             (motorSubindoF),
        .motorDescendoF            (motorDescendoF),
        .trigger_sensor_ultrasonico(trigger),
        .saida_andar               (saida_andar)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    function automatic logic sig(input int which);
        case (which)
            SIG_UP:   return motorSubindoF;
            SIG_DOWN: return motorDescendoF;
            default:  return trigger;
        endcase
    endfunction

    // Returns the number of negedges waited, or -1 if the budget expired.
    task automatic wait_sig(input int which, input logic val, input int budget, output int cyc);
        cyc = 0;
        while (sig(which) !== val && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        if (sig(which) !== val) cyc = -1;
    endtask

    task automatic count_trig(input int window, output int n);
        logic prev;
        n    = 0;
        prev = trigger;
        repeat (window) begin
            @(negedge clk);
            if (trigger && !prev) n++;
            prev = trigger;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        RX = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            repeat (CPB) @(negedge clk);
        end
        RX = stop;
        repeat (CPB) @(negedge clk);
        RX = 1'b1;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic set_sensors(input logic [3:0] s);
        sensoresNeg = s;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, trig_w, n_down, n, moving;

        reset = 1'b1; iniciar = 1'b0; sensoresNeg = 4'hF;
        emergencia = 1'b0; RX = 1'b1; echo = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {motorSubindoF, motorDescendoF, trigger, saida_andar}, 5'b0);
        reset = 1'b0;
        iniciar = 1'b1;
        repeat (50) @(negedge clk);
        check("idle_no_activity", {motorSubindoF, motorDescendoF, trigger, saida_andar}, 5'b0);

        // Single request 0x1C: origin 0, destination 3, from the ground floor.
        sensoresNeg = 4'b1110;
        trig_w = 0; n_down = 0; cyc = -1;
        fork
            send_byte(8'h1C, 1'b1);
            begin
                wait_sig(SIG_TRIG, 1'b1, 400, cyc);
                check("load_trigger_seen", cyc != -1, 1);
                cyc = 0;
                while (!motorSubindoF && cyc < 2000) begin
                    if (trigger) trig_w++;
                    if (motorDescendoF) n_down++;
                    @(negedge clk);
                    cyc++;
                end
            end
        join
        check("load_trigger_width", trig_w, TRIG);
        check("load_to_up_latency", cyc, DWELL + 1);
        check("load_no_down", n_down, 0);

        set_sensors(4'b1101);
        check("floor1", {motorSubindoF, saida_andar}, {1'b1, 2'd1});
        set_sensors(4'b1111);
        check("between_floors_hold", saida_andar, 2'd1);
        set_sensors(4'b1011);
        check("floor2", {motorSubindoF, saida_andar}, {1'b1, 2'd2});
        set_sensors(4'b0111);
        check("arrive_dest_stop", {motorSubindoF, motorDescendoF, saida_andar}, {2'b00, 2'd3});
        check("unload_trigger", trigger, 1'b1);
        repeat (DWELL + 10) @(negedge clk);
        check("idle_after_unload", {motorSubindoF, motorDescendoF, trigger}, 3'b0);

        // 0x1E: origin 2, destination 3, starting at floor 3.
        send_byte(8'h1E, 1'b1);
        wait_sig(SIG_DOWN, 1'b1, 50, cyc);
        check("reverse_down", {cyc != -1, motorSubindoF}, 2'b10);
        set_sensors(4'b1011);
        check("reverse_stop", {motorDescendoF, saida_andar}, {1'b0, 2'd2});
        wait_sig(SIG_UP, 1'b1, DWELL + 50, cyc);
        check("forward_up", cyc != -1, 1);

        emergencia = 1'b1;
        repeat (3) @(negedge clk);
        check("emerg_stop", {motorSubindoF, motorDescendoF}, 2'b00);
        repeat (30) @(negedge clk);
        check("emerg_hold", {motorSubindoF, motorDescendoF}, 2'b00);
        emergencia = 1'b0;
        wait_sig(SIG_UP, 1'b1, 10, cyc);
        check("emerg_resume_up", {cyc != -1, motorDescendoF}, 2'b10);
        set_sensors(4'b0111);
        check("forward_stop", {motorSubindoF, saida_andar}, {1'b0, 2'd3});
        repeat (DWELL + 10) @(negedge clk);

        // Bad stop bit: nothing may be queued.
        send_byte(8'h0F, 1'b0);
        count_trig(300, n);
        check("bad_stop_dropped", n, 0);

        // Five same-floor requests while blocked: four served, two pulses each.
        iniciar = 1'b0;
        send_byte(8'h0F, 1'b1);
        send_byte(8'h1F, 1'b1);
        send_byte(8'h2F, 1'b1);
        send_byte(8'h3F, 1'b1);
        send_byte(8'hCF, 1'b1);
        count_trig(100, n);
        check("iniciar_blocks", n, 0);
        iniciar = 1'b1;
        count_trig(2500, n);
        check("four_served", n, 8);
        check("same_floor_no_motion", {motorSubindoF, motorDescendoF}, 2'b00);

        // Obstacle: 0x0B = origin 3, destination 2, echo held high.
        echo = 1'b1;
        send_byte(8'h0B, 1'b1);
        moving = 0;
        repeat (3 * DWELL + 100) begin
            @(negedge clk);
            if (motorSubindoF || motorDescendoF) moving++;
        end
        check("obstacle_no_motion", moving, 0);
        echo = 1'b0;
        wait_sig(SIG_DOWN, 1'b1, DWELL + 50, cyc);
        check("obstacle_clear_down", cyc != -1, 1);

        reset = 1'b1;
        #1;
        check("reset_mid_motion", {motorSubindoF, motorDescendoF, trigger, saida_andar}, 5'b0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("floor_after_reset", saida_andar, 2'd3);

        // Queued request lost across reset.
        iniciar = 1'b0;
        send_byte(8'h0F, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        iniciar = 1'b1;
        count_trig(400, n);
        check("queue_cleared_by_reset", n, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
